seq_div8: RTL and testbench
===========================

SEQ_DIV8 -- requirements
Module: seq_div8

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port Resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: launches a division when sampled high in IDLE.
REQ-005 The block SHALL have port Dividend, input, n bits: the numerator, sampled with Start.
REQ-006 The block SHALL have port Divisor, input, n bits: the denominator, sampled with Start.
REQ-007 The block SHALL have port Quotient, output, n bits: the registered quotient.
REQ-008 The block SHALL have port Remainder, output, n bits: the registered remainder.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while in state RUN.
REQ-010 The block SHALL have port Done, output, 1 bit: a one-cycle pulse that marks new results.
REQ-011 The block SHALL have port DivZero, output, 1 bit: the last operation had Divisor = 0.
REQ-012 The block SHALL have port Overflow, output, 1 bit: signed overflow of the last operation; it SHALL be tied to 0 when the signed build is off.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 IDLE with Start = 1 at edge k and Divisor != 0: the block SHALL register both operands, clear the step counter and go to RUN.
REQ-015 IDLE with Start = 1 at edge k and Divisor = 0: the block SHALL go to DONE, load Quotient = all ones and Remainder = Dividend, and set DivZero = 1.
REQ-016 RUN SHALL perform one restoring shift-subtract step per clock.
- Partial remainder is n+1 bits: shift left by one and bring in the next dividend bit, MSB first.
- Subtract the divisor; restore the partial remainder if the result is negative.
- Quotient bit = 1 when the subtraction succeeds.
REQ-017 After exactly n RUN steps (edge k+n), the block SHALL write Quotient and Remainder, clear DivZero and go to DONE.
REQ-018 Done SHALL be high only during the DONE cycle, and the state SHALL return to IDLE on the next edge.
REQ-019 Result latency from the Start edge SHALL be:
- Divisor != 0: Done high in the cycle following edge k+n.
- Divisor = 0: Done high in the cycle following edge k.
REQ-020 The block SHALL ignore Start in RUN and DONE; operand changes during RUN SHALL have no effect.
REQ-021 Quotient, Remainder, DivZero and Overflow SHALL hold their values until the next operation completes.
REQ-022 Back-to-back operation: the block SHALL accept a Start held high through DONE at the first IDLE edge after DONE.

Reset
REQ-023 Resetn = 0 SHALL immediately force state IDLE and clear Quotient, Remainder, Busy, Done, DivZero, Overflow and all internal registers to 0.
REQ-024 Reset during RUN SHALL abort the operation without producing a Done pulse.
REQ-025 The first Start after Resetn rises SHALL behave per REQ-014/015.

Configuration
REQ-026 When the macro SEQ_DIV8_SIGNED_EN is defined, the block SHALL treat operands as two's complement.
- Divide the magnitudes using the same n-step latency.
- Negate the quotient when the operand signs differ.
- Give the remainder the sign of the dividend.
- Most-negative / -1: Quotient = most-negative value, Remainder = 0, Overflow = 1.
- Divide by zero: Quotient = all ones, Remainder = Dividend.
REQ-027 When SEQ_DIV8_SIGNED_EN is undefined, the block SHALL perform unsigned division only, with Overflow constant 0.

Verification
REQ-028 (unsigned, n = 8) Dividend = 100, Divisor = 7, Start pulse -> Busy for 8 cycles, then Done for 1 cycle with Quotient = 14, Remainder = 2, DivZero = 0.
REQ-029 (unsigned) Dividend = 0xFF, Divisor = 0x01 -> Quotient = 0xFF, Remainder = 0x00; Dividend = 0x05, Divisor = 0x10 -> Quotient = 0x00, Remainder = 0x05.
REQ-030 Dividend = 5, Divisor = 0 -> Done in the cycle after the Start edge, Quotient = 0xFF, Remainder = 0x05, DivZero = 1, Busy never high.
REQ-031 Start re-pulsed with new operands at RUN step 3 -> ignored, original result delivered; Resetn low at RUN step 4 -> all outputs 0, no Done, and the next Start works.
REQ-032 (SEQ_DIV8_SIGNED_EN) Dividend = 0x9C (-100), Divisor = 7 -> Quotient = 0xF2 (-14), Remainder = 0xFE (-2).
REQ-033 (SEQ_DIV8_SIGNED_EN) Dividend = 0x80, Divisor = 0xFF -> Quotient = 0x80, Remainder = 0x00, Overflow = 1.

Source files
------------

// File: rtl/seq_div8.sv
// Sequential n-bit restoring divider: one quotient bit per clock, result after n RUN cycles.
// Define SEQ_DIV8_SIGNED_EN for two's-complement operands with overflow detection.
module seq_div8 #(
    parameter int unsigned n = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Start,
    input  logic [n-1:0] Dividend,
    input  logic [n-1:0] Divisor,
    output logic [n-1:0] Quotient,
    output logic [n-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero,
    output logic         Overflow
);

    localparam int unsigned CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [n-1:0]  dvd_q;
    logic [n-1:0]  dvs_q;
    logic [n-1:0]  rem_q;

    logic [n:0]    shift_c;
    logic [n:0]    diff_c;
    logic [n-1:0]  rem_nxt_c;
    logic [n-1:0]  quo_nxt_c;
    logic [n-1:0]  dvd_mag_c;
    logic [n-1:0]  dvs_mag_c;

    // One restoring step: dividend bits leave at the MSB, quotient bits enter at the LSB.
    always_comb begin
        shift_c   = {rem_q, dvd_q[n-1]};
        diff_c    = shift_c - {1'b0, dvs_q};
        rem_nxt_c = diff_c[n] ? shift_c[n-1:0] : diff_c[n-1:0];
        quo_nxt_c = {dvd_q[n-2:0], ~diff_c[n]};
    end

`ifdef SEQ_DIV8_SIGNED_EN
    localparam logic [n-1:0] MOST_NEG = {1'b1, {(n-1){1'b0}}};

    logic qneg_q;
    logic rneg_q;
    logic ovf_q;

    always_comb begin
        dvd_mag_c = Dividend[n-1] ? n'(-Dividend) : Dividend;
        dvs_mag_c = Divisor[n-1]  ? n'(-Divisor)  : Divisor;
    end
`else
    always_comb begin
        dvd_mag_c = Dividend;
        dvs_mag_c = Divisor;
    end

    assign Overflow = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
`ifdef SEQ_DIV8_SIGNED_EN
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            ovf_q     <= 1'b0;
            Overflow  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (Divisor == '0) begin
                            // Divide by zero resolves immediately without entering RUN.
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivZero   <= 1'b1;
                            Done      <= 1'b1;
`ifdef SEQ_DIV8_SIGNED_EN
                            Overflow  <= 1'b0;
`endif
                            state_q   <= DONE;
                        end else begin
                            dvd_q   <= dvd_mag_c;
                            dvs_q   <= dvs_mag_c;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            Busy    <= 1'b1;
`ifdef SEQ_DIV8_SIGNED_EN
                            qneg_q  <= Dividend[n-1] ^ Divisor[n-1];
                            rneg_q  <= Dividend[n-1];
                            ovf_q   <= (Dividend == MOST_NEG) && (Divisor == '1);
`endif
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    dvd_q <= quo_nxt_c;
                    rem_q <= rem_nxt_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(n - 1)) begin
`ifdef SEQ_DIV8_SIGNED_EN
                        Quotient  <= qneg_q ? n'(-quo_nxt_c) : quo_nxt_c;
                        Remainder <= rneg_q ? n'(-rem_nxt_c) : rem_nxt_c;
                        Overflow  <= ovf_q;
`else
                        Quotient  <= quo_nxt_c;
                        Remainder <= rem_nxt_c;
`endif
                        DivZero   <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div8.sv
// Randomized self-checking bench for seq_div8 against an arithmetic reference model.
module tb_seq_div8;

    localparam int unsigned N = 8;

    logic         Clock;
    logic         Resetn;
    logic         Start;
    logic [N-1:0] Dividend;
    logic [N-1:0] Divisor;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic         Overflow;

    int n_checks = 0;
    int n_errors = 0;

    seq_div8 #(.n(N)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer division following the divide-by-zero and overflow rules.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic dz, output logic ov);
`ifdef SEQ_DIV8_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = (b == 0);
        ov = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sa == -(1 << (N - 1)) && sb == -1) begin
            q = a;
            r = '0;
            ov = 1'b1;
        end else begin
            q = N'(sa / sb);
            r = N'(sa % sb);
        end
`else
        dz = (b == 0);
        ov = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = N'(int'(a) / int'(b));
            r = N'(int'(a) % int'(b));
        end
`endif
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // From the cycle after the Start edge, wait for Done and check latency, Busy and results.
    task automatic collect(input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble);
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic dz;
        logic ov;
        int lat;
        int busy_cnt;
        int exp_lat;
        model(a, b, q, r, dz, ov);
        exp_lat = (b == 0) ? 0 : int'(N);
        lat = 0;
        busy_cnt = 0;
        while (!Done && lat < int'(N) + 4) begin
            if (Busy) busy_cnt++;
            if (scramble) begin
                Start    = 1'($urandom_range(0, 1));
                Dividend = N'($urandom);
                Divisor  = N'($urandom);
            end
            tick();
            lat++;
        end
        Start = 1'b0;
        check("done_seen", 32'(Done), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
        check("quotient", 32'(Quotient), 32'(q));
        check("remainder", 32'(Remainder), 32'(r));
        check("divzero", 32'(DivZero), 32'(dz));
        check("overflow", 32'(Overflow), 32'(ov));
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble);
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic dz;
        logic ov;
        model(a, b, q, r, dz, ov);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        collect(a, b, scramble);
        tick();
        check("done_pulse_end", 32'(Done), 32'd0);
        check("busy_after", 32'(Busy), 32'd0);
        Dividend = N'($urandom);
        Divisor  = N'($urandom);
        tick();
        check("hold_quotient", 32'(Quotient), 32'(q));
        check("hold_remainder", 32'(Remainder), 32'(r));
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        int done_seen;

        Resetn   = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #12;
        check("rst_quotient", 32'(Quotient), 32'd0);
        check("rst_remainder", 32'(Remainder), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_divzero", 32'(DivZero), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        Resetn = 1'b1;
        tick();

        // Directed cases from the requirement examples.
        run_op(8'd100, 8'd7, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h05, 8'h10, 1'b0);
        run_op(8'd5, 8'd0, 1'b0);
        run_op(8'h9C, 8'd7, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0);
        run_op(8'd100, 8'd7, 1'b1);

        // Back-to-back: Start held high through DONE launches the next operation.
        Dividend = 8'd200;
        Divisor  = 8'd9;
        Start    = 1'b1;
        tick();
        collect(8'd200, 8'd9, 1'b0);
        Dividend = 8'd77;
        Divisor  = 8'd5;
        Start    = 1'b1;
        tick();
        check("b2b_idle_done", 32'(Done), 32'd0);
        check("b2b_idle_busy", 32'(Busy), 32'd0);
        tick();
        Start = 1'b0;
        check("b2b_busy", 32'(Busy), 32'd1);
        collect(8'd77, 8'd5, 1'b0);
        tick();

        // Reset in the middle of RUN aborts without a Done pulse.
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Resetn = 1'b0;
        #1;
        check("abort_quotient", 32'(Quotient), 32'd0);
        check("abort_remainder", 32'(Remainder), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_divzero", 32'(DivZero), 32'd0);
        #3;
        Resetn = 1'b1;
        done_seen = 0;
        repeat (N + 3) begin
            tick();
            if (Done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op(8'd250, 8'd3, 1'b0);

        // Randomized operations with occasional zero and tiny divisors.
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 3));
                default: b = N'($urandom);
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
